// File: rtl/uart_tx.sv
// UART transmitter: a byte FIFO feeds an 8N1 serialiser, sent LSB first on tx_p.
// The serialiser advances one bit per baud_1_x_p tick and runs back-to-back frames with no idle gap.
module uart_tx #(
  parameter int FIFO_DEPTH_c  = 16,
  parameter int FIFO_ADDR_W_c = 4
) (
  input  logic                     clk210_p,
  input  logic                     reset_p,
  input  logic                     baud_1_x_p,
  input  logic [7:0]               fifo_tx_din_p,
  input  logic                     fifo_tx_wr_en_p,
  output logic                     fifo_tx_full_p,
  output logic                     fifo_tx_empty_p,
  output logic [FIFO_ADDR_W_c:0]   fifo_tx_data_count_p,
  output logic                     fifo_tx_overflow_p,
  output logic                     tx_p,
  output logic                     tx_busy_p,
  output logic                     transmit_done_p
);

  localparam logic [FIFO_ADDR_W_c:0]   DEPTH_c   = (FIFO_ADDR_W_c+1)'(FIFO_DEPTH_c);
  localparam logic [FIFO_ADDR_W_c:0]   CNT_ONE_c = (FIFO_ADDR_W_c+1)'(1);
  localparam logic [FIFO_ADDR_W_c-1:0] PTR_ONE_c = FIFO_ADDR_W_c'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                   state;
  logic [7:0]               mem [FIFO_DEPTH_c];
  logic [FIFO_ADDR_W_c-1:0] wr_ptr;
  logic [FIFO_ADDR_W_c-1:0] rd_ptr;
  logic [FIFO_ADDR_W_c:0]   count;
  logic [7:0]               shift;
  logic [2:0]               bit_cnt;
  logic                     wr_accept;
  logic                     pop;

  assign fifo_tx_full_p       = (count == DEPTH_c);
  assign fifo_tx_empty_p      = (count == '0);
  assign fifo_tx_data_count_p = count;

  // Pop happens on the tick that launches a start bit, from IDLE or straight out of STOP.
  always_comb begin
    wr_accept = fifo_tx_wr_en_p && !fifo_tx_full_p;
    pop       = baud_1_x_p && !fifo_tx_empty_p && ((state == IDLE) || (state == STOP));
  end

  always_ff @(posedge clk210_p) begin
    if (wr_accept) begin
      mem[wr_ptr] <= fifo_tx_din_p;
    end
  end

  always_ff @(posedge clk210_p) begin
    if (!reset_p) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      fifo_tx_overflow_p <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE_c;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE_c;
      end
      if (fifo_tx_wr_en_p && fifo_tx_full_p) begin
        fifo_tx_overflow_p <= 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + CNT_ONE_c;
        2'b01:   count <= count - CNT_ONE_c;
        default: count <= count;
      endcase
    end
  end

  // The shift register moves right so the next data bit is always at shift[0].
  always_ff @(posedge clk210_p) begin
    if (!reset_p) begin
      state           <= IDLE;
      tx_p            <= 1'b1;
      tx_busy_p       <= 1'b0;
      transmit_done_p <= 1'b0;
      shift           <= '0;
      bit_cnt         <= '0;
    end else begin
      transmit_done_p <= 1'b0;
      if (baud_1_x_p) begin
        case (state)
          IDLE: begin
            if (pop) begin
              shift     <= mem[rd_ptr];
              tx_p      <= 1'b0;
              tx_busy_p <= 1'b1;
              state     <= START;
            end else begin
              tx_p      <= 1'b1;
              tx_busy_p <= 1'b0;
            end
          end
          START: begin
            tx_p    <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_p    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end else begin
              tx_p  <= 1'b1;
              state <= STOP;
            end
          end
          STOP: begin
            transmit_done_p <= 1'b1;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx_p  <= 1'b0;
              state <= START;
            end else begin
              tx_p      <= 1'b1;
              tx_busy_p <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            tx_p      <= 1'b1;
            tx_busy_p <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue-based model of the FIFO and serial line is
// compared against the DUT one cycle at a time, across directed and randomized traffic.
module tb_uart_tx;

  logic       clk210_p = 1'b0;
  logic       reset_p = 1'b0;
  logic       baud_1_x_p = 1'b0;
  logic [7:0] fifo_tx_din_p = 8'h00;
  logic       fifo_tx_wr_en_p = 1'b0;
  logic       fifo_tx_full_p;
  logic       fifo_tx_empty_p;
  logic [4:0] fifo_tx_data_count_p;
  logic       fifo_tx_overflow_p;
  logic       tx_p;
  logic       tx_busy_p;
  logic       transmit_done_p;

  always #5 clk210_p = ~clk210_p;

  uart_tx #(
    .FIFO_DEPTH_c(16),
    .FIFO_ADDR_W_c(4)
  ) dut (
    .clk210_p(clk210_p),
    .reset_p(reset_p),
    .baud_1_x_p(baud_1_x_p),
    .fifo_tx_din_p(fifo_tx_din_p),
    .fifo_tx_wr_en_p(fifo_tx_wr_en_p),
    .fifo_tx_full_p(fifo_tx_full_p),
    .fifo_tx_empty_p(fifo_tx_empty_p),
    .fifo_tx_data_count_p(fifo_tx_data_count_p),
    .fifo_tx_overflow_p(fifo_tx_overflow_p),
    .tx_p(tx_p),
    .tx_busy_p(tx_busy_p),
    .transmit_done_p(transmit_done_p)
  );

  // Reference model: queued bytes plus the line bits still to be sent for the current frame.
  logic [7:0] m_fifo[$];
  logic       m_bits[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_ovf = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int baud_div = 1;
  int baud_phase = 0;
  int done_cnt = 0;
  logic tick_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelEdge(input logic rst_n, input logic wr, input logic [7:0] din, input logic b);
    int pre;
    logic [7:0] v;
    if (!rst_n) begin
      m_fifo.delete();
      m_bits.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
      return;
    end
    pre    = m_fifo.size();
    m_done = 1'b0;
    if (b) begin
      if (m_bits.size() > 0) begin
        m_tx = m_bits.pop_front();
      end else begin
        if (m_busy) m_done = 1'b1;
        if (pre > 0) begin
          v = m_fifo.pop_front();
          for (int i = 0; i < 8; i++) m_bits.push_back(v[i]);
          m_bits.push_back(1'b1);
          m_tx   = 1'b0;
          m_busy = 1'b1;
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    if (wr) begin
      if (pre < 16) m_fifo.push_back(din);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic checkOutput();
    chk("tx_p", tx_p, m_tx);
    chk("tx_busy", tx_busy_p, m_busy);
    chk("transmit_done", transmit_done_p, m_done);
    chk("data_count", fifo_tx_data_count_p, m_fifo.size());
    chk("empty", fifo_tx_empty_p, m_fifo.size() == 0);
    chk("full", fifo_tx_full_p, m_fifo.size() == 16);
    chk("overflow", fifo_tx_overflow_p, m_ovf);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic wr, input logic [7:0] din);
    logic b;
    @(negedge clk210_p);
    if (baud_div == 0) begin
      b = 1'b0;
    end else begin
      b = (baud_phase == 0);
      baud_phase = (baud_phase + 1) % baud_div;
    end
    reset_p         = rst_n;
    fifo_tx_wr_en_p = wr;
    fifo_tx_din_p   = din;
    baud_1_x_p      = b;
    @(posedge clk210_p);
    modelEdge(rst_n, wr, din, b);
    #1;
    checkOutput();
    if (b && (tx_busy_p || transmit_done_p)) tick_log.push_back(tx_p);
    if (transmit_done_p) done_cnt++;
  endtask

  task automatic setBaud(input int div);
    baud_div   = div;
    baud_phase = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((m_fifo.size() != 0 || m_busy) && n < max_cycles) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      n++;
    end
    chk("drain_in_budget", (m_fifo.size() == 0 && !m_busy), 1);
  endtask

  initial begin
    logic [9:0] obs;
    int n;

    $display("[TB] reset");
    setBaud(4);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00);

    $display("[TB] single byte 0xA5");
    tick_log.delete();
    done_cnt = 0;
    applyStimulus(1'b1, 1'b1, 8'hA5);
    drain(500);
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00);
    obs = '0;
    if (tick_log.size() >= 10) begin
      for (int i = 0; i < 10; i++) obs[9-i] = tick_log[i];
    end
    chk("a5_line_bits", obs, 10'b0101001011);
    chk("a5_done_pulses", done_cnt, 1);

    $display("[TB] burst 0xA0..0xA4");
    setBaud(3);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'hA0 + 8'(i));
    drain(1000);
    chk("burst_done_pulses", done_cnt, 5);

    $display("[TB] overflow with baud held low");
    setBaud(0);
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    chk("ovf_count", fifo_tx_data_count_p, 16);
    chk("ovf_flag", fifo_tx_overflow_p, 1);
    setBaud(2);
    done_cnt = 0;
    drain(2000);
    chk("ovf_frames_sent", done_cnt, 16);

    $display("[TB] reset mid-frame");
    done_cnt = 0;
    applyStimulus(1'b1, 1'b1, 8'h3C);
    n = 0;
    while (m_bits.size() != 5 && n < 200) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      n++;
    end
    chk("reach_bit3", m_bits.size(), 5);
    applyStimulus(1'b0, 1'b0, 8'h00);
    chk("rst_tx", tx_p, 1);
    chk("rst_busy", tx_busy_p, 0);
    chk("rst_count", fifo_tx_data_count_p, 0);
    chk("rst_no_done", done_cnt, 0);
    applyStimulus(1'b1, 1'b1, 8'h55);
    drain(500);
    chk("post_rst_frame", done_cnt, 1);

    $display("[TB] write during STOP pop, continuous baud");
    setBaud(1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'h11 * 8'(i + 1));
    n = 0;
    while (!(m_busy && m_bits.size() == 0 && m_fifo.size() == 2) && n < 100) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      n++;
    end
    chk("stop_with_two", m_fifo.size(), 2);
    applyStimulus(1'b1, 1'b1, 8'h77);
    chk("simul_count", fifo_tx_data_count_p, 2);
    drain(500);

    $display("[TB] randomized traffic");
    for (int seg = 0; seg < 4; seg++) begin
      setBaud($urandom_range(1, 4));
      for (int c = 0; c < 80; c++) begin
        applyStimulus(1'b1, ($urandom_range(0, 2) == 0), 8'($urandom));
      end
      drain(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
